// File: rtl/display_output_port.sv
// Three-digit 7-segment output port: captures a 16-bit value, converts it to BCD
// by double-dabble and registers the segment patterns. DISPLAY_BLANK_LEADING_EN blanks leading zeros.
module display_output_port #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        out_valid,
  input  logic [15:0] out_data,
  output logic        busy,
  output logic [6:0]  outputA,
  output logic [6:0]  outputB,
  output logic [6:0]  outputC
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_CONV    = 2'd1;
  localparam logic [1:0]  S_DONE    = 2'd2;

  localparam logic [3:0]  LAST_STEP = 4'd9;
  localparam logic [15:0] MAX_VALUE = 16'd999;

  // Raw patterns are active-high, bit0 = segment a ... bit6 = segment g.
  localparam logic [6:0]  SEG_ZERO  = 7'b0111111;
  localparam logic [6:0]  SEG_DASH  = 7'b1000000;
  localparam logic [6:0]  SEG_BLANK = 7'b0000000;

`ifdef DISPLAY_BLANK_LEADING_EN
  localparam bit          BLANK_LEADING = 1'b1;
  localparam logic [6:0]  RESET_A_RAW   = SEG_BLANK;
  localparam logic [6:0]  RESET_B_RAW   = SEG_BLANK;
`else
  localparam bit          BLANK_LEADING = 1'b0;
  localparam logic [6:0]  RESET_A_RAW   = SEG_ZERO;
  localparam logic [6:0]  RESET_B_RAW   = SEG_ZERO;
`endif
  localparam logic [6:0]  RESET_C_RAW   = SEG_ZERO;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [6:0] seg_polarity(input logic [6:0] seg);
    return SEG_ACTIVE_LOW ? ~seg : seg;
  endfunction

  function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [9:0]  shift_q, shift_d;
  logic [11:0] bcd_q,   bcd_d;
  logic        ovf_q,   ovf_d;
  logic [6:0]  seg_a_q, seg_a_d;
  logic [6:0]  seg_b_q, seg_b_d;
  logic [6:0]  seg_c_q, seg_c_d;

  logic [11:0] bcd_adj;
  logic        blank_h;
  logic        blank_t;
  logic [6:0]  raw_a;
  logic [6:0]  raw_b;
  logic [6:0]  raw_c;

  assign bcd_adj = {dabble_adjust(bcd_q[11:8]),
                    dabble_adjust(bcd_q[7:4]),
                    dabble_adjust(bcd_q[3:0])};

  // Tens is blanked only when hundreds is blanked too, so "105" keeps its zero.
  assign blank_h = BLANK_LEADING && (bcd_q[11:8] == 4'd0);
  assign blank_t = blank_h && (bcd_q[7:4] == 4'd0);

  always_comb begin
    raw_a = seg_decode(bcd_q[11:8]);
    raw_b = seg_decode(bcd_q[7:4]);
    raw_c = seg_decode(bcd_q[3:0]);
    if (ovf_q) begin
      raw_a = SEG_DASH;
      raw_b = SEG_DASH;
      raw_c = SEG_DASH;
    end else begin
      if (blank_h) raw_a = SEG_BLANK;
      if (blank_t) raw_b = SEG_BLANK;
    end
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    seg_a_d = seg_a_q;
    seg_b_d = seg_b_q;
    seg_c_d = seg_c_q;

    case (state_q)
      S_IDLE: begin
        if (out_valid) begin
          shift_d = out_data[9:0];
          bcd_d   = '0;
          cnt_d   = '0;
          if (out_data > MAX_VALUE) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            ovf_d   = 1'b0;
            state_d = S_CONV;
          end
        end
      end

      S_CONV: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        cnt_d            = cnt_q + 4'd1;
        if (cnt_q == LAST_STEP) state_d = S_DONE;
      end

      S_DONE: begin
        seg_a_d = seg_polarity(raw_a);
        seg_b_d = seg_polarity(raw_b);
        seg_c_d = seg_polarity(raw_c);
        ovf_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      seg_a_q <= seg_polarity(RESET_A_RAW);
      seg_b_q <= seg_polarity(RESET_B_RAW);
      seg_c_q <= seg_polarity(RESET_C_RAW);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      seg_a_q <= seg_a_d;
      seg_b_q <= seg_b_d;
      seg_c_q <= seg_c_d;
    end
  end

  assign busy    = (state_q == S_CONV) || (state_q == S_DONE);
  assign outputA = seg_a_q;
  assign outputB = seg_b_q;
  assign outputC = seg_c_q;

endmodule

// File: tb/tb_display_output_port.sv
// Self-checking bench for display_output_port: scenario tasks compared against a
// decimal-arithmetic reference model of the display (honours DISPLAY_BLANK_LEADING_EN).
module tb_display_output_port;

  logic        clock = 1'b0;
  logic        reset;
  logic        out_valid;
  logic [15:0] out_data;
  logic        busy;
  logic [6:0]  outputA;
  logic [6:0]  outputB;
  logic [6:0]  outputC;

  int checks = 0;
  int errors = 0;

  // What the display is currently expected to show.
  logic [6:0] disp_a, disp_b, disp_c;

  display_output_port #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .clock    (clock),
    .reset    (reset),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy),
    .outputA  (outputA),
    .outputB  (outputB),
    .outputC  (outputC)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Active-high segment table, digits 0..9; the DUT under test is active-low.
  function automatic logic [6:0] ref_seg(input int d);
    logic [6:0] table_hi [10];
    table_hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return ~table_hi[d];
  endfunction

  function automatic logic [20:0] ref_display(input int v);
    logic [6:0] a, b, c;
    int h, t, u;
    if (v > 999) begin
      a = ~7'h40; b = ~7'h40; c = ~7'h40;
    end else begin
      h = v / 100;
      t = (v / 10) % 10;
      u = v % 10;
      a = ref_seg(h);
      b = ref_seg(t);
      c = ref_seg(u);
`ifdef DISPLAY_BLANK_LEADING_EN
      if (h == 0) a = 7'h7F;
      if (h == 0 && t == 0) b = 7'h7F;
`endif
    end
    return {a, b, c};
  endfunction

  function automatic logic [20:0] ref_reset();
`ifdef DISPLAY_BLANK_LEADING_EN
    return {7'h7F, 7'h7F, ref_seg(0)};
`else
    return {ref_seg(0), ref_seg(0), ref_seg(0)};
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issues one write and follows it to completion, checking busy and the outputs each cycle.
  task automatic run_write(input logic [15:0] v);
    logic [20:0] exp_disp;
    exp_disp  = ref_display(int'(v));
    out_valid = 1'b1;
    out_data  = v;
    step();
    out_valid = 1'b0;
    out_data  = 16'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_E0 (%0d): got %b expected 1", v, busy);
    end
    if (v <= 16'd999) begin
      for (int k = 1; k <= 10; k++) begin
        step();
        checks++;
        if (busy !== 1'b1 || {outputA, outputB, outputC} !== {disp_a, disp_b, disp_c}) begin
          errors++;
          $display("FAIL busy_hold (%0d) E%0d: got busy=%b out=%b_%b_%b expected busy=1 out=%b_%b_%b",
                   v, k, busy, outputA, outputB, outputC, disp_a, disp_b, disp_c);
        end
      end
    end
    step();
    {disp_a, disp_b, disp_c} = exp_disp;
    checks++;
    if (busy !== 1'b0 || {outputA, outputB, outputC} !== exp_disp) begin
      errors++;
      $display("FAIL display (%0d): got busy=%b out=%b_%b_%b expected busy=0 out=%b_%b_%b",
               v, busy, outputA, outputB, outputC, disp_a, disp_b, disp_c);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    out_valid = 1'b1;
    out_data  = 16'd123;
    step();
    step();
    {disp_a, disp_b, disp_c} = ref_reset();
    checks++;
    if (busy !== 1'b0 || {outputA, outputB, outputC} !== {disp_a, disp_b, disp_c}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b out=%b_%b_%b expected busy=0 out=%b_%b_%b",
               busy, outputA, outputB, outputC, disp_a, disp_b, disp_c);
    end
    reset     = 1'b0;
    out_valid = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_spec_vectors();
    run_write(16'd123);
    checks++;
    if ({outputA, outputB, outputC} !== {7'b1111001, 7'b0100100, 7'b0110000}) begin
      errors++;
      $display("FAIL vector_123: got %b_%b_%b expected 1111001_0100100_0110000",
               outputA, outputB, outputC);
    end
    run_write(16'd999);
    checks++;
    if ({outputA, outputB, outputC} !== {3{7'b0010000}}) begin
      errors++;
      $display("FAIL vector_999: got %b_%b_%b expected 0010000 x3", outputA, outputB, outputC);
    end
    run_write(16'd1000);
    checks++;
    if ({outputA, outputB, outputC} !== {3{7'b0111111}}) begin
      errors++;
      $display("FAIL vector_1000: got %b_%b_%b expected 0111111 x3", outputA, outputB, outputC);
    end
    run_write(16'd65535);
    checks++;
    if ({outputA, outputB, outputC} !== {3{7'b0111111}}) begin
      errors++;
      $display("FAIL vector_65535: got %b_%b_%b expected 0111111 x3", outputA, outputB, outputC);
    end
    run_write(16'd7);
    checks++;
`ifdef DISPLAY_BLANK_LEADING_EN
    if ({outputA, outputB, outputC} !== {7'b1111111, 7'b1111111, 7'b1111000}) begin
      errors++;
      $display("FAIL vector_7: got %b_%b_%b expected 1111111_1111111_1111000",
               outputA, outputB, outputC);
    end
`else
    if ({outputA, outputB, outputC} !== {7'b1000000, 7'b1000000, 7'b1111000}) begin
      errors++;
      $display("FAIL vector_7: got %b_%b_%b expected 1000000_1000000_1111000",
               outputA, outputB, outputC);
    end
`endif
  endtask

  task automatic test_boundaries();
    logic [15:0] vals [8];
    vals = '{16'd0, 16'd10, 16'd100, 16'd105, 16'd998, 16'd1023, 16'd1024, 16'd50000};
    for (int i = 0; i < 8; i++) run_write(vals[i]);
  endtask

  task automatic test_ignore_while_busy();
    logic [20:0] exp_disp;
    exp_disp  = ref_display(123);
    out_valid = 1'b1;
    out_data  = 16'd123;
    step();
    out_valid = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    out_valid = 1'b1;
    out_data  = 16'd456;
    step();
    out_valid = 1'b0;
    for (int k = 6; k <= 11; k++) step();
    {disp_a, disp_b, disp_c} = exp_disp;
    checks++;
    if (busy !== 1'b0 || {outputA, outputB, outputC} !== exp_disp) begin
      errors++;
      $display("FAIL ignore_busy_result: got busy=%b out=%b_%b_%b expected busy=0 out=%b_%b_%b",
               busy, outputA, outputB, outputC, disp_a, disp_b, disp_c);
    end
    for (int k = 0; k < 14; k++) step();
    checks++;
    if (busy !== 1'b0 || {outputA, outputB, outputC} !== exp_disp) begin
      errors++;
      $display("FAIL ignore_busy_no_queue: got busy=%b out=%b_%b_%b expected busy=0 out=%b_%b_%b",
               busy, outputA, outputB, outputC, disp_a, disp_b, disp_c);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v1, v2;
    v1 = 16'($urandom_range(0, 999));
    v2 = 16'($urandom_range(0, 999));
    out_valid = 1'b1;
    out_data  = v1;
    step();
    for (int k = 1; k <= 10; k++) step();
    out_data = v2;
    step();
    {disp_a, disp_b, disp_c} = ref_display(int'(v1));
    checks++;
    if (busy !== 1'b0 || {outputA, outputB, outputC} !== {disp_a, disp_b, disp_c}) begin
      errors++;
      $display("FAIL b2b_first (%0d): got busy=%b out=%b_%b_%b expected busy=0 out=%b_%b_%b",
               v1, busy, outputA, outputB, outputC, disp_a, disp_b, disp_c);
    end
    step();
    out_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_capture (%0d): got busy=%b expected 1", v2, busy);
    end
    for (int k = 1; k <= 11; k++) step();
    {disp_a, disp_b, disp_c} = ref_display(int'(v2));
    checks++;
    if (busy !== 1'b0 || {outputA, outputB, outputC} !== {disp_a, disp_b, disp_c}) begin
      errors++;
      $display("FAIL b2b_second (%0d): got busy=%b out=%b_%b_%b expected busy=0 out=%b_%b_%b",
               v2, busy, outputA, outputB, outputC, disp_a, disp_b, disp_c);
    end
  endtask

  // Starts a write of v, asserts reset on edge E<abort_edge> (with out_valid also high)
  // and checks that the display falls back to the reset pattern and stays there.
  task automatic abort_write(input logic [15:0] v, input int abort_edge);
    out_valid = 1'b1;
    out_data  = v;
    step();
    out_valid = 1'b0;
    for (int k = 1; k < abort_edge; k++) step();
    reset     = 1'b1;
    out_valid = 1'b1;
    out_data  = 16'd789;
    step();
    reset     = 1'b0;
    out_valid = 1'b0;
    {disp_a, disp_b, disp_c} = ref_reset();
    checks++;
    if (busy !== 1'b0 || {outputA, outputB, outputC} !== {disp_a, disp_b, disp_c}) begin
      errors++;
      $display("FAIL abort_E%0d (%0d): got busy=%b out=%b_%b_%b expected busy=0 out=%b_%b_%b",
               abort_edge, v, busy, outputA, outputB, outputC, disp_a, disp_b, disp_c);
    end
    for (int k = 0; k < 13; k++) step();
    checks++;
    if (busy !== 1'b0 || {outputA, outputB, outputC} !== {disp_a, disp_b, disp_c}) begin
      errors++;
      $display("FAIL abort_hold_E%0d (%0d): got busy=%b out=%b_%b_%b expected busy=0 out=%b_%b_%b",
               abort_edge, v, busy, outputA, outputB, outputC, disp_a, disp_b, disp_c);
    end
  endtask

  task automatic test_reset_abort();
    run_write(16'd123);
    abort_write(16'd456, 6);
    run_write(16'd456);
    abort_write(16'd258, 11);
    run_write(16'd860);
    abort_write(16'd1000, 1);
    run_write(16'd42);
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) v = 16'($urandom_range(1000, 65535));
      else                           v = 16'($urandom_range(0, 999));
      run_write(v);
      for (int g = $urandom_range(0, 3); g > 0; g--) step();
    end
  endtask

  initial begin
    reset     = 1'b1;
    out_valid = 1'b0;
    out_data  = '0;
    disp_a    = '0;
    disp_b    = '0;
    disp_c    = '0;
    test_reset();
    test_spec_vectors();
    test_boundaries();
    test_ignore_while_busy();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_output_port.md
DISPLAY_OUTPUT_PORT -- requirements
Module: display_output_port

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 1: when 1, segment outputs are active-low; when 0, active-high.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 out_valid  input  1  CPU OUT-instruction strobe; out_data is valid while high.
REQ-005 out_data  input  16  unsigned value to display.
REQ-006 busy  output  1  high while a captured value is being converted.
REQ-007 outputA  output  7  hundreds digit; bit0=seg a … bit6=seg g.
REQ-008 outputB  output  7  tens digit, same encoding.
REQ-009 outputC  output  7  units digit, same encoding.

Function
REQ-010 FSM states SHALL be IDLE, CONV and DONE.
REQ-011 In IDLE, when out_valid=1, out_data SHALL be captured at that edge (E0).
- If out_data ≤ 999, the next state SHALL be CONV.
- Otherwise, the next state SHALL be DONE with the overflow flag set.
REQ-012 CONV SHALL run the double-dabble algorithm on the low 10 bits, one bit per cycle, for exactly 10 cycles (E1..E10), tracked by a 4-bit counter.
- Each cycle: first add 3 to any BCD nibble ≥ 5, then shift left one bit.
REQ-013 DONE SHALL last one cycle.
- At its edge, the three digit patterns SHALL be registered into outputA/B/C and the state SHALL return to IDLE.
- Normal path: outputs update at E11. Overflow path: outputs update at E1.
REQ-014 busy SHALL be 1 exactly when the state is CONV or DONE, and 0 in IDLE.
REQ-015 out_valid while busy=1 SHALL be ignored: no capture, no queuing, and the ongoing conversion is unaffected.
REQ-016 Digit decode SHALL cover digits 0–9 with standard 7-segment patterns.
- Active-high patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 7=0000111, 9=1101111.
- When SEG_ACTIVE_LOW=1, every pattern is bitwise inverted.
REQ-017 Overflow (value > 999) SHALL drive all three digits to '-' (segment g only).
REQ-018 Outputs SHALL hold their last registered value between updates.
- Outputs SHALL be registered, never combinational from the converter state.
REQ-019 A back-to-back out_valid arriving in the same cycle that the state returns to IDLE SHALL be captured on the next edge.

Reset
REQ-020 On any edge with reset=1, the block SHALL enter IDLE.
- busy=0, the counter is cleared, the BCD and shift registers are cleared, and the overflow flag is cleared.
REQ-021 Reset SHALL set the outputs to the reset pattern.
- Without the macro: "000".
- With the macro: blank, blank, "0".
REQ-022 Reset asserted mid-CONV or in DONE SHALL abort the conversion with no display update from the aborted value.
- reset SHALL take priority over out_valid.

Configuration
REQ-023 Macro DISPLAY_BLANK_LEADING_EN, when defined, SHALL enable leading-zero suppression.
- A zero hundreds digit is blanked (all segments off).
- A zero tens digit is blanked only if hundreds is also zero.
- Units is never blanked.
- Overflow '-' is unaffected.
REQ-024 Without DISPLAY_BLANK_LEADING_EN, all three digits SHALL always be displayed, including leading zeros.

Verification (SEG_ACTIVE_LOW=1, macro undefined unless stated)
REQ-025 Write 123:
- busy=1 from E1 through E11.
- After E11: outputA=1111001, outputB=0100100, outputC=0110000.
REQ-026 Write 999:
- After E11: all three outputs = 0010000.
REQ-027 Write 1000, then write 65535:
- Each write: busy high for one cycle.
- After E1: all outputs = 0111111 ('-').
REQ-028 Write 7:
- Macro undefined: after E11, A=1000000, B=1000000, C=1111000.
- Macro defined: A=1111111, B=1111111, C=1111000.
REQ-029 Write 123, then pulse out_valid with 456 at E5:
- Displays show 123 after E11.
- 456 is never displayed.
REQ-030 Display 123, write 456, assert reset at E6:
- Next edge: busy=0 and outputs show the reset pattern "000" (1000000 ×3).
- A subsequent write of 456 displays correctly.
